// File: rtl/cnt_sched_pkg.sv
// cnt_sched_pkg -- shared types and constants for the cnt_sched counter scheduler.
//   state_e : FSM state enum (IDLE, COUNT, DONE)
//   CNT_W   : width of the shared up-counter
//   NREQ    : number of requesters
//   onehot  : turns a requester index into its one-hot grant/done vector
package cnt_sched_pkg;

    localparam int CNT_W = 3;
    localparam int NREQ  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_e;

    function automatic logic [NREQ-1:0] onehot(input logic idx);
        onehot = idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/cnt_sched_upcnt3.sv
// upcnt3 -- 3-bit synchronous up counter with clear and enable.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset, forces q to 0
//   clr   : synchronous clear, has priority over en
//   en    : advance by one on the next edge
//   q     : current count
module upcnt3
    import cnt_sched_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] q
);

    logic [CNT_W-1:0] q_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else if (clr) begin
            q_q <= '0;
        end else if (en) begin
            q_q <= q_q + 1'b1;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/cnt_sched.sv
// cnt_sched -- two-requester round-robin scheduler for one shared 3-bit up-counter.
// A granted requester owns the counter for len+1 counts, then gets a one-cycle
// done pulse. Dropping req mid-run aborts the run without a done pulse.
//
// Build option: define CNT_SCHED_PAUSE_EN to make the pause input freeze the
// counter; without it pause is present but ignored.
//
// Ports:
//   clk       : clock, rising edge
//   reset     : asynchronous active-low reset
//   req       : per-requester count request, level-held
//   len0/len1 : terminal count for requester 0/1 (run is len+1 counts)
//   pause     : freezes the counter while high (CNT_SCHED_PAUSE_EN builds only)
//   gnt       : one-hot, high while that requester owns the counter
//   done      : one-hot, one-cycle completion pulse to the owner
//   busy      : high whenever the FSM is not IDLE
//   count_out : shared counter value
//
// state | meaning
// IDLE  | counter held at 0, arbitrate pending requests
// COUNT | owner granted, counter advancing up to the latched len
// DONE  | one-cycle done pulse, count holds final value, record last owner
module cnt_sched
    import cnt_sched_pkg::*;
#(
    parameter int DEF_PRIO = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NREQ-1:0]  req,
    input  logic [CNT_W-1:0] len0,
    input  logic [CNT_W-1:0] len1,
    input  logic             pause,
    output logic [NREQ-1:0]  gnt,
    output logic [NREQ-1:0]  done,
    output logic             busy,
    output logic [CNT_W-1:0] count_out
);

    // Last owner starts as the other requester so DEF_PRIO wins the first tie.
    localparam logic RST_LAST = (DEF_PRIO == 0) ? 1'b1 : 1'b0;

    state_e           state_q, state_d;
    logic             owner_q, owner_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] len_q, len_d;

    logic             pause_eff;
    logic             win;
    logic             owner_req;
    logic             cnt_clr;
    logic             cnt_en;
    logic [CNT_W-1:0] cnt;

`ifdef CNT_SCHED_PAUSE_EN
    assign pause_eff = pause;
`else
    logic unused_pause;
    assign unused_pause = pause;
    assign pause_eff    = 1'b0;
`endif

    // Single request wins outright; on a tie the non-last owner wins.
    assign win       = (req == 2'b11) ? ~last_q : ~req[0];
    assign owner_req = req[owner_q];

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        len_d   = len_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_clr = 1'b1;
                if (|req) begin
                    state_d = COUNT;
                    owner_d = win;
                    len_d   = win ? len1 : len0;
                end
            end
            COUNT: begin
                // Abort wins over pause and over reaching the terminal count.
                if (!owner_req) begin
                    state_d = IDLE;
                    cnt_clr = 1'b1;
                    last_d  = owner_q;
                end else if (!pause_eff) begin
                    if (cnt == len_q) begin
                        state_d = DONE;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
            end
            DONE: begin
                cnt_clr = 1'b1;
                last_d  = owner_q;
                state_d = IDLE;
            end
            default: begin
                cnt_clr = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= RST_LAST;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            len_q   <= len_d;
        end
    end

    upcnt3 u_cnt (
        .clk   (clk),
        .rst_n (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .q     (cnt)
    );

    assign gnt       = (state_q == COUNT) ? onehot(owner_q) : '0;
    assign done      = (state_q == DONE)  ? onehot(owner_q) : '0;
    assign busy      = (state_q != IDLE);
    assign count_out = cnt;

endmodule

// File: doc/cnt_sched.md
CNT_SCHED -- requirements
Module: cnt_sched

Interface
REQ-001 The block SHALL have parameter DEF_PRIO, default 0, which selects the requester that wins the first tie after reset.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit; reset is asynchronous and active-low.
REQ-004 The block SHALL have port req, input, 2 bits, one count request per requester (0, 1), level-held.
REQ-005 The block SHALL have ports len0 and len1, input, 3 bits each, the terminal count for each requester (a run is len+1 counts).
REQ-006 The block SHALL have port pause, input, 1 bit; when high it freezes the counter.
REQ-007 The block SHALL have port gnt, output, 2 bits, a one-hot grant that is high while that requester owns the counter.
REQ-008 The block SHALL have port done, output, 2 bits, a one-cycle completion pulse to the owner.
REQ-009 The block SHALL have port busy, output, 1 bit, high whenever the state is not IDLE.
REQ-010 The block SHALL have port count_out, output, 3 bits, the shared up-counter value.

Function
REQ-011 The FSM SHALL have exactly three states (IDLE, COUNT, DONE); the internal last-owner bit SHALL record the most recently served requester.
REQ-012 In IDLE with req != 0, the FSM SHALL go to COUNT on the next edge, assert gnt for the winner, latch that requester's len, and set count_out=0.
REQ-013 Arbitration SHALL give a single request to its requester; when both requests are set, the requester that is not the last owner SHALL win (round-robin).
REQ-014 In COUNT with pause low, count_out SHALL increment by 1 per cycle, as unsigned 3-bit.
REQ-015 When count_out equals the latched len and pause is low, the FSM SHALL go to DONE; count_out SHALL NOT wrap past 7 within a run.
REQ-016 Latency: req seen in IDLE at cycle N SHALL give gnt at N+1 and done at N+2+len, with pause never asserted.
REQ-017 In DONE, gnt SHALL be 0, done[owner] SHALL be 1 for exactly one cycle, count_out SHALL hold its final value, last-owner SHALL update, and the next state SHALL be IDLE.
REQ-018 In IDLE, count_out SHALL be 0 and done SHALL be 0; arbitration of new requests SHALL NOT happen in DONE, so the minimum gap between grants is 2 cycles.
REQ-019 If the owner drops req during COUNT, the run SHALL be aborted: the FSM returns to IDLE on the next edge, done stays 0, count_out is cleared to 0, and last-owner is updated to the aborted owner.
REQ-020 A change to len0 or len1 during COUNT SHALL NOT affect the current run.
REQ-021 A non-owner request during COUNT SHALL be held pending and arbitrated in the next IDLE.

Reset
REQ-022 While reset is low, the block SHALL force state to IDLE, gnt=0, done=0, busy=0, count_out=0, and last-owner to the requester other than DEF_PRIO, independent of clk.
REQ-023 Reset asserted mid-run SHALL abort the run immediately with no done pulse; the first grant after release SHALL follow REQ-012 and REQ-013.

Configuration
REQ-024 With macro CNT_SCHED_PAUSE_EN defined, pause SHALL behave as in REQ-006 and REQ-014.
REQ-025 Without CNT_SCHED_PAUSE_EN, the pause port SHALL remain present but be ignored, so the counter advances every COUNT cycle.

Structure
REQ-026 Package cnt_sched_pkg SHALL hold the state enum (IDLE, COUNT, DONE), CNT_W=3, and NREQ=2.
REQ-027 The counter SHALL be sub-module upcnt3, a 3-bit synchronous up counter with clr and en inputs, asynchronous active-low reset, and output q.
REQ-028 Arbitration and FSM logic SHALL reside in cnt_sched.

Verification
REQ-029 Scenario: reset low, then released; req=01, len0=3 -> gnt=01 at cycle 1; count_out 0,1,2,3; done=01 at cycle 5; busy low at cycle 6.
REQ-030 Scenario: after reset with DEF_PRIO=0, req=11 held, len0=0, len1=1 -> grants in the order 01, 10, 01, each separated by DONE and IDLE cycles.
REQ-031 Scenario: len1=7, pause high for 2 cycles at count_out=4 -> count_out holds 4 for 2 cycles, and done arrives 2 cycles late.
REQ-031a Scenario: repeat REQ-031 without the macro -> pause is ignored and done arrives on time.
REQ-032 Scenario: owner 0 drops req at count_out=2 -> IDLE next cycle, done=00, count_out=0, and a pending req1 is granted next.
REQ-033 Scenario: reset low at count_out=5 -> all outputs 0 asynchronously and no done pulse.
REQ-034 Scenario: len0 changed from 2 to 6 at count_out=1 -> the run still ends at count_out=2.
